fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 Parameter NOP_INST, default 16'h0000, encoding driven into the IF/ID register as a bubble.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  hazard hold from decode; freezes PC and the IF/ID register.
REQ-006 flush  input  1  taken branch/return from execute; redirects PC and bubbles IF/ID.
REQ-007 branch_target  input  16  redirect PC, sampled when flush=1.
REQ-008 halt_in  input  1  decoded HALT in decode, qualified by inst_valid.
REQ-009 imem_addr  output  16  instruction memory address, equal to the current PC.
REQ-010 imem_rd_en  output  1  instruction memory read enable.
REQ-011 imem_data  input  16  instruction word, combinational read of imem_addr in the same cycle.
REQ-012 inst  output  16  registered instruction to decode.
REQ-013 pc_out  output  16  registered PC of inst.
REQ-014 pc_plus1  output  16  registered pc_out+1, used as the link value.
REQ-015 inst_valid  output  1  inst holds a real instruction (not a bubble).
REQ-016 halted  output  1  fetch has stopped on HALT.
REQ-017 fetch_cnt  output  32  count of valid instructions delivered (see Configuration).
REQ-018 flush_cnt  output  16  count of flushes accepted (see Configuration).

Function
REQ-019 FSM has two states: RUN and HALTED; halted=1 only in HALTED.
REQ-020 In RUN with stall=0 and flush=0: PC<=PC+1; inst<=imem_data; pc_out<=PC; pc_plus1<=PC+1; inst_valid<=1.
REQ-021 Fetch-to-decode latency is one cycle: the word at imem_addr in cycle N appears on inst in cycle N+1.
REQ-022 PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000, with no flag raised.
REQ-023 imem_rd_en=1 exactly when state=RUN and stall=0, or when flush=1.
REQ-024 flush=1 (any state, overriding stall): PC<=branch_target; inst<=NOP_INST; inst_valid<=0; state<=RUN.
REQ-025 stall=1 with flush=0: PC, inst, pc_out, pc_plus1 and inst_valid all hold their values.
REQ-026 halt_in=1 with flush=0 in RUN: state<=HALTED; PC holds; IF/ID takes a bubble (inst=NOP_INST, inst_valid=0), regardless of stall.
REQ-027 flush and halt_in asserted in the same cycle: flush wins, because the branch is older; HALT is discarded.
REQ-028 In HALTED without flush: PC frozen; imem_rd_en=0; IF/ID holds the bubble; halt_in is ignored. The block leaves HALTED only on reset or flush.

Reset
REQ-029 With rst_n=0 at a rising edge: PC<=RESET_PC; state<=RUN; inst<=NOP_INST; pc_out<=RESET_PC; pc_plus1<=RESET_PC+1; inst_valid<=0; fetch_cnt<=0; flush_cnt<=0.
REQ-030 Reset overrides stall, flush and halt_in, and takes effect mid-operation, including from HALTED.
REQ-031 In the first cycle after rst_n rises: imem_addr=RESET_PC and imem_rd_en=1, provided stall=0.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: fetch_cnt +1 on each cycle where inst_valid is loaded with 1; flush_cnt +1 on each cycle with flush=1. Both counters saturate at all-ones.
REQ-033 FETCH_PERF_CNT_EN undefined: counter registers are not built; fetch_cnt and flush_cnt are tied to 0; ports remain present.

Verification
REQ-034 Reset, then free run with imem[i]=16'h1000+i -> cycle 1: inst=16'h1000, pc_out=0, pc_plus1=1; cycle 3: inst=16'h1002, inst_valid=1.
REQ-035 stall=1 for 2 cycles while pc_out=5 -> inst, pc_out and imem_addr=6 are held; the cycle after release gives pc_out=6.
REQ-036 flush=1 with branch_target=16'h0040, and stall=1 in the same cycle -> next cycle: inst_valid=0, inst=NOP_INST, imem_addr=16'h0040; the cycle after: pc_out=16'h0040.
REQ-037 halt_in=1 at PC=9 -> halted=1, imem_rd_en=0, imem_addr stays 9, inst_valid=0 for 10 cycles; then flush to 16'h0100 -> RUN, with pc_out=16'h0100 two cycles after the flush.
REQ-038 halt_in and flush together (target 16'h0020) -> halted stays 0, and PC=16'h0020 follows; with PC=16'hFFFF free-running -> next imem_addr=16'h0000.
REQ-039 With FETCH_PERF_CNT_EN: 10 valid fetches and 2 flushes -> fetch_cnt=10, flush_cnt=2; rst_n=0 mid-run -> both counters return to 0 and PC=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port, and
// the IF/ID register contents handed to decode.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic [15:0] branch_target;
  logic        halt_in;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_data;
  logic [15:0] inst;
  logic [15:0] pc_out;
  logic [15:0] pc_plus1;
  logic        inst_valid;
  logic        halted;
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;

  modport master (
    input  stall, flush, branch_target, halt_in, imem_data,
    output imem_addr, imem_rd_en, inst, pc_out, pc_plus1, inst_valid,
           halted, fetch_cnt, flush_cnt
  );

  modport slave (
    output stall, flush, branch_target, halt_in, imem_data,
    input  imem_addr, imem_rd_en, inst, pc_out, pc_plus1, inst_valid,
           halted, fetch_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register and RUN/HALTED control.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [15:0] pc_plus1_q, pc_plus1_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fetch_inc;
  logic        flush_inc;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd1;

  // Priority: flush (older branch) > HALT in RUN > stall > normal advance.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    pc_plus1_d   = pc_plus1_q;
    inst_valid_d = inst_valid_q;
    fetch_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (bus.flush) begin
      state_d      = RUN;
      pc_d         = bus.branch_target;
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
      flush_inc    = 1'b1;
    end else if (state_q == RUN) begin
      if (bus.halt_in && inst_valid_q) begin
        state_d      = HALTED;
        inst_d       = NOP_INST;
        inst_valid_d = 1'b0;
      end else if (!bus.stall) begin
        pc_d         = pc_inc;
        inst_d       = bus.imem_data;
        pc_out_d     = pc_q;
        pc_plus1_d   = pc_inc;
        inst_valid_d = 1'b1;
        fetch_inc    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      pc_out_q     <= RESET_PC;
      pc_plus1_q   <= RESET_PC + 16'd1;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      pc_plus1_q   <= pc_plus1_d;
      inst_valid_q <= inst_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fetch_inc && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  logic unused_inc;
  assign unused_inc    = fetch_inc ^ flush_inc;
  assign bus.fetch_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

  assign bus.imem_addr  = pc_q;
  assign bus.imem_rd_en = ((state_q == RUN) && !bus.stall) || bus.flush;
  assign bus.inst       = inst_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.pc_plus1   = pc_plus1_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.halted     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage with a rule-level reference model.
module tb_fetch_stage;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'hBEEF;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fetch_stage_if ifc ();

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: word i holds 16'h1000 + i.
  assign ifc.imem_data = 16'h1000 + ifc.imem_addr;

  // Reference model state.
  bit          m_init = 0;
  logic [15:0] m_pc, m_inst, m_pc_out, m_pc_p1;
  logic        m_valid, m_halted;
  logic [31:0] m_fcnt;
  logic [15:0] m_flcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_regs();
    chk("imem_addr",  {16'h0, ifc.imem_addr},  {16'h0, m_pc});
    chk("inst",       {16'h0, ifc.inst},       {16'h0, m_inst});
    chk("pc_out",     {16'h0, ifc.pc_out},     {16'h0, m_pc_out});
    chk("pc_plus1",   {16'h0, ifc.pc_plus1},   {16'h0, m_pc_p1});
    chk("inst_valid", {31'h0, ifc.inst_valid}, {31'h0, m_valid});
    chk("halted",     {31'h0, ifc.halted},     {31'h0, m_halted});
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt",  ifc.fetch_cnt,           m_fcnt);
    chk("flush_cnt",  {16'h0, ifc.flush_cnt},  {16'h0, m_flcnt});
`else
    chk("fetch_cnt",  ifc.fetch_cnt,           32'h0);
    chk("flush_cnt",  {16'h0, ifc.flush_cnt},  32'h0);
`endif
  endtask

  // One clock: drive inputs, check the combinational read enable, advance the
  // model by the stage's rules, then check every registered output.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic [15:0] t, input logic h);
    rst_n             = r;
    ifc.stall         = s;
    ifc.flush         = f;
    ifc.branch_target = t;
    ifc.halt_in       = h;
    #1;
    if (m_init)
      chk("imem_rd_en", {31'h0, ifc.imem_rd_en}, {31'h0, (!m_halted && !s) || f});
    if (!r) begin
      m_init = 1; m_pc = RST_PC; m_inst = NOP; m_pc_out = RST_PC;
      m_pc_p1 = RST_PC + 16'd1; m_valid = 0; m_halted = 0; m_fcnt = 0; m_flcnt = 0;
    end else if (f) begin
      m_pc = t; m_inst = NOP; m_valid = 0; m_halted = 0;
      if (m_flcnt != 16'hFFFF) m_flcnt++;
    end else if (!m_halted) begin
      if (h && m_valid) begin
        m_halted = 1; m_inst = NOP; m_valid = 0;
      end else if (!s) begin
        m_inst = 16'h1000 + m_pc; m_pc_out = m_pc; m_pc_p1 = m_pc + 16'd1;
        m_pc = m_pc + 16'd1; m_valid = 1;
        if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      end
    end
    @(posedge clk);
    #1;
    if (m_init) check_regs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 16'h0, 0);
  endtask

  initial begin
    rst_n = 0; ifc.stall = 0; ifc.flush = 0; ifc.branch_target = '0; ifc.halt_in = 0;

    // Reset with every control input asserted.
    step(0, 1, 1, 16'h1234, 1);
    step(0, 0, 0, 16'h0, 0);
    chk("rst_inst", {16'h0, ifc.inst}, {16'h0, NOP});
    chk("rst_addr", {16'h0, ifc.imem_addr}, {16'h0, RST_PC});
    ifc.stall = 0; #1;
    chk("rst_rd_en", {31'h0, ifc.imem_rd_en}, 32'h1);

    // Free run from reset.
    run(1);
    chk("fr1_inst", {16'h0, ifc.inst}, 32'h1000);
    chk("fr1_pc_out", {16'h0, ifc.pc_out}, 32'h0);
    chk("fr1_pc_plus1", {16'h0, ifc.pc_plus1}, 32'h1);
    run(2);
    chk("fr3_inst", {16'h0, ifc.inst}, 32'h1002);
    chk("fr3_valid", {31'h0, ifc.inst_valid}, 32'h1);
    run(3);
    chk("pre_stall_pc_out", {16'h0, ifc.pc_out}, 32'h5);

    // Two-cycle stall.
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 16'h0, 0);
      chk("stall_pc_out", {16'h0, ifc.pc_out}, 32'h5);
      chk("stall_addr", {16'h0, ifc.imem_addr}, 32'h6);
      chk("stall_inst", {16'h0, ifc.inst}, 32'h1005);
    end
    run(1);
    chk("post_stall_pc_out", {16'h0, ifc.pc_out}, 32'h6);

    // Flush overriding stall.
    step(1, 1, 1, 16'h0040, 0);
    chk("fl_valid", {31'h0, ifc.inst_valid}, 32'h0);
    chk("fl_inst", {16'h0, ifc.inst}, {16'h0, NOP});
    chk("fl_addr", {16'h0, ifc.imem_addr}, 32'h40);
    run(1);
    chk("fl_pc_out", {16'h0, ifc.pc_out}, 32'h40);

    // HALT at PC=9, then ten cycles parked with halt_in/stall toggling.
    step(1, 0, 1, 16'h0007, 0);
    run(2);
    chk("pre_halt_addr", {16'h0, ifc.imem_addr}, 32'h9);
    step(1, 1, 0, 16'h0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1'($urandom_range(0, 1)), 0, 16'h0, 1'($urandom_range(0, 1)));
      chk("halt_halted", {31'h0, ifc.halted}, 32'h1);
      chk("halt_rd_en", {31'h0, ifc.imem_rd_en}, 32'h0);
      chk("halt_addr", {16'h0, ifc.imem_addr}, 32'h9);
      chk("halt_valid", {31'h0, ifc.inst_valid}, 32'h0);
    end
    step(1, 0, 1, 16'h0100, 0);
    chk("unhalt", {31'h0, ifc.halted}, 32'h0);
    run(1);
    chk("unhalt_pc_out", {16'h0, ifc.pc_out}, 32'h100);

    // Flush and HALT together: flush wins.
    step(1, 0, 1, 16'h0020, 1);
    chk("hf_halted", {31'h0, ifc.halted}, 32'h0);
    chk("hf_addr", {16'h0, ifc.imem_addr}, 32'h20);
    run(1);
    chk("hf_pc_out", {16'h0, ifc.pc_out}, 32'h20);

    // PC wrap.
    step(1, 0, 1, 16'hFFFE, 0);
    run(2);
    chk("wrap_addr", {16'h0, ifc.imem_addr}, 32'h0);
    chk("wrap_pc_out", {16'h0, ifc.pc_out}, 32'hFFFF);
    chk("wrap_pc_plus1", {16'h0, ifc.pc_plus1}, 32'h0);

    // Counters: 10 valid fetches and 2 flushes, then mid-run reset.
    step(0, 0, 0, 16'h0, 0);
    step(1, 0, 1, 16'h0010, 0);
    run(10);
    step(1, 0, 1, 16'h0030, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt_fetch", ifc.fetch_cnt, 32'd10);
    chk("cnt_flush", {16'h0, ifc.flush_cnt}, 32'd2);
`endif
    run(3);
    step(0, 1, 1, 16'h5555, 1);
    chk("mid_rst_fetch", ifc.fetch_cnt, 32'd0);
    chk("mid_rst_flush", {16'h0, ifc.flush_cnt}, 32'd0);
    chk("mid_rst_addr", {16'h0, ifc.imem_addr}, {16'h0, RST_PC});

    // Reset out of HALTED.
    run(2);
    step(1, 0, 0, 16'h0, 1);
    chk("halt2", {31'h0, ifc.halted}, 32'h1);
    step(0, 0, 0, 16'h0, 0);
    chk("rst_from_halt", {31'h0, ifc.halted}, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) >= 2),
           1'($urandom_range(0, 99) < 25),
           1'($urandom_range(0, 99) < 10),
           16'($urandom),
           1'($urandom_range(0, 99) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
